// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the MIPS-subset core: sequences fetch/decode/execute/memory/
// write-back over a shared ALU and memory port, and counts retired instructions.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  func,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  npc_sel,
   output logic        reg_we,
   output logic        RegDst,
   output logic        raLink,
   output logic        MemtoReg,
   output logic        aluSource,
   output logic [1:0]  EXTCtrl,
   output logic [2:0]  aluCtrl,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        instr_done,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      InsAdd, InsSub, InsOri, InsLw, InsSw, InsBeq, InsLui, InsJal, InsJr, InsBad
   } ins_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJal   = 6'h03;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpOri   = 6'h0d;
   localparam logic [5:0] OpLui   = 6'h0f;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2b;
   localparam logic [5:0] FnAdd   = 6'h20;
   localparam logic [5:0] FnSub   = 6'h22;
   localparam logic [5:0] FnJr    = 6'h08;

   localparam logic [1:0] NpcSeq  = 2'b00;
   localparam logic [1:0] NpcBr   = 2'b01;
   localparam logic [1:0] NpcJal  = 2'b10;
   localparam logic [1:0] NpcJr   = 2'b11;

   localparam logic [1:0] ExtSign = 2'b00;
   localparam logic [1:0] ExtZero = 2'b01;
   localparam logic [1:0] ExtLui  = 2'b10;
   localparam logic [1:0] ExtBr   = 2'b11;

   localparam logic [2:0] AluAdd  = 3'b010;
   localparam logic [2:0] AluSub  = 3'b110;
   localparam logic [2:0] AluOr   = 3'b001;

   state_e      state_q, state_d;
   ins_e        ins;
   logic [2:0]  alu_dec;
   logic        src_dec;
   logic [1:0]  ext_dec;
   logic [31:0] retired_q;

   // Instruction class from the IR fields; stable from DECODE until the instruction ends.
   always_comb begin
      ins = InsBad;
      case (opcode)
         OpRtype: begin
            case (func)
               FnAdd:   ins = InsAdd;
               FnSub:   ins = InsSub;
               FnJr:    ins = InsJr;
               default: ins = InsBad;
            endcase
         end
         OpJal:   ins = InsJal;
         OpBeq:   ins = InsBeq;
         OpOri:   ins = InsOri;
         OpLui:   ins = InsLui;
         OpLw:    ins = InsLw;
         OpSw:    ins = InsSw;
         default: ins = InsBad;
      endcase
   end

   // lui adds the shifted immediate to the $0 operand, so it shares the add encoding.
   always_comb begin
      alu_dec = 3'b000;
      src_dec = 1'b0;
      ext_dec = ExtSign;
      case (ins)
         InsAdd: alu_dec = AluAdd;
         InsSub: alu_dec = AluSub;
         InsOri: begin
            alu_dec = AluOr;
            src_dec = 1'b1;
            ext_dec = ExtZero;
         end
         InsLui: begin
            alu_dec = AluAdd;
            src_dec = 1'b1;
            ext_dec = ExtLui;
         end
         InsLw, InsSw: begin
            alu_dec = AluAdd;
            src_dec = 1'b1;
            ext_dec = ExtSign;
         end
         InsBeq: begin
            alu_dec = AluSub;
            ext_dec = ExtBr;
         end
         default: begin
            alu_dec = 3'b000;
            src_dec = 1'b0;
            ext_dec = ExtSign;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      npc_sel    = NpcSeq;
      reg_we     = 1'b0;
      RegDst     = 1'b0;
      raLink     = 1'b0;
      MemtoReg   = 1'b0;
      aluSource  = 1'b0;
      EXTCtrl    = ExtSign;
      aluCtrl    = 3'b000;
      illegal    = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               npc_sel = NpcSeq;
               state_d = StDecode;
            end
         end
         StDecode: begin
            case (ins)
               InsJal: begin
                  pc_we      = 1'b1;
                  npc_sel    = NpcJal;
                  reg_we     = 1'b1;
                  raLink     = 1'b1;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               InsJr: begin
                  pc_we      = 1'b1;
                  npc_sel    = NpcJr;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               InsBad: begin
                  illegal = 1'b1;
                  state_d = StFetch;
               end
               default: state_d = StExec;
            endcase
         end
         StExec: begin
            aluCtrl   = alu_dec;
            aluSource = src_dec;
            EXTCtrl   = ext_dec;
            case (ins)
               InsBeq: begin
                  pc_we      = zero;
                  npc_sel    = NpcBr;
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
               InsLw, InsSw:                  state_d = StMem;
               InsAdd, InsSub, InsOri, InsLui: state_d = StWb;
               default:                       state_d = StFetch;
            endcase
         end
         StMem: begin
            aluCtrl   = alu_dec;
            aluSource = src_dec;
            EXTCtrl   = ext_dec;
            mem_req   = 1'b1;
            mem_we    = (ins == InsSw);
            if (mem_ready) begin
               if (ins == InsLw) begin
                  state_d = StWb;
               end else begin
                  instr_done = 1'b1;
                  state_d    = StFetch;
               end
            end
         end
         StWb: begin
            aluCtrl    = alu_dec;
            aluSource  = src_dec;
            EXTCtrl    = ext_dec;
            reg_we     = 1'b1;
            RegDst     = (ins == InsAdd) || (ins == InsSub);
            MemtoReg   = (ins == InsLw);
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired_q <= 32'd0;
      end else if (instr_done) begin
         retired_q <= retired_q + 32'd1;
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

   // Memory-port and retirement invariants of the sequencing above.
   a_we_needs_req : assert property (@(posedge clk) disable iff (!reset) mem_we |-> mem_req);
   a_req_states : assert property (@(posedge clk) disable iff (!reset)
      mem_req |-> (state_q == StFetch || state_q == StMem));
   a_ill_quiet : assert property (@(posedge clk) disable iff (!reset)
      illegal |-> !(pc_we || reg_we || instr_done || mem_req));

endmodule
